// File: rtl/seg_frame_sender.sv
// Serialises 24-bit segment/LED frames MSB first to a display shift register, then latches them.
// Optional macro FRAME_REPEAT_EN: resend the last accepted frame after IDLE_REFRESH idle cycles.
module seg_frame_sender #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned IDLE_REFRESH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  input  logic [23:0] frame_data,
  output logic        frame_ready,
  output logic        sclk,
  output logic        sdata,
  output logic        slatch,
  output logic        busy
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("seg_frame_sender: CLK_DIV must be in 1..255");
  end
  if (IDLE_REFRESH < 1 || IDLE_REFRESH > 65535) begin : g_bad_idle_refresh
    $error("seg_frame_sender: IDLE_REFRESH must be in 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    GAP
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_e      state_q;
  logic [23:0] shift_q;
  logic [4:0]  bit_cnt_q;
  logic [7:0]  div_q;
  logic        sclk_q;
  logic        sdata_q;
  logic        slatch_q;
  logic        busy_q;
  logic        ready_q;

  logic        div_done;
  logic        start_d;
  logic [23:0] start_data_d;

  assign div_done = (div_q == DIV_LAST);

`ifdef FRAME_REPEAT_EN
  localparam logic [15:0] REFRESH_LAST = 16'(IDLE_REFRESH - 1);

  logic [23:0] hold_q;
  logic [15:0] refresh_q;
  logic        have_frame_q;
  logic        refresh_due;

  assign refresh_due = have_frame_q && (refresh_q == REFRESH_LAST);

  // A fresh frame from the requester always beats a pending resend.
  always_comb begin
    start_d      = 1'b0;
    start_data_d = frame_data;
    if (ready_q && frame_valid) begin
      start_d = 1'b1;
    end else if (ready_q && refresh_due) begin
      start_d      = 1'b1;
      start_data_d = hold_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= '0;
      refresh_q    <= '0;
      have_frame_q <= 1'b0;
    end else begin
      if (ready_q && frame_valid) begin
        hold_q       <= frame_data;
        have_frame_q <= 1'b1;
      end
      if (state_q != IDLE || start_d) begin
        refresh_q <= '0;
      end else if (refresh_q != REFRESH_LAST) begin
        refresh_q <= refresh_q + 16'd1;
      end
    end
  end
`else
  assign start_d      = ready_q & frame_valid;
  assign start_data_d = frame_data;
`endif

  // Every timed state lasts exactly CLK_DIV cycles; outputs are registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      slatch_q  <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (start_d) begin
            shift_q   <= start_data_d;
            bit_cnt_q <= 5'd23;
            div_q     <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= start_data_d[23];
            slatch_q  <= 1'b0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (div_done) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= SHIFT_HI;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        SHIFT_HI: begin
          if (div_done) begin
            div_q   <= '0;
            sclk_q  <= 1'b0;
            shift_q <= {shift_q[22:0], 1'b0};
            if (bit_cnt_q == 5'd0) begin
              slatch_q <= 1'b1;
              state_q  <= LATCH;
            end else begin
              bit_cnt_q <= bit_cnt_q - 5'd1;
              sdata_q   <= shift_q[22];
              state_q   <= SHIFT_LO;
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        LATCH: begin
          if (div_done) begin
            div_q    <= '0;
            slatch_q <= 1'b0;
            state_q  <= GAP;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        GAP: begin
          if (div_done) begin
            div_q   <= '0;
            sdata_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        default: begin
          div_q    <= '0;
          sclk_q   <= 1'b0;
          sdata_q  <= 1'b0;
          slatch_q <= 1'b0;
          busy_q   <= 1'b0;
          ready_q  <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign frame_ready = ready_q;
  assign sclk        = sclk_q;
  assign sdata       = sdata_q;
  assign slatch      = slatch_q;
  assign busy        = busy_q;

endmodule

// File: doc/seg_frame_sender.md
SEG_FRAME_SENDER -- requirements
Module: seg_frame_sender

Interface
REQ-001 Parameter CLK_DIV, default 4: serial clock half-period in clk cycles; legal range 1..255.
REQ-002 Parameter IDLE_REFRESH, default 256: idle clk cycles before an automatic frame resend; legal range 1..65535; used only under FRAME_REPEAT_EN.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 frame_valid  in  1  requester has a frame on frame_data.
REQ-006 frame_data  in  24  frame payload: [22:16] red segments, [14:8] green segments, [6:0] LEDs; bits 23, 15 and 7 are spare and are transmitted as given.
REQ-007 frame_ready  out  1  sender can accept a frame this cycle.
REQ-008 sclk  out  1  serial shift clock to the display shift register; the display samples sdata on its rising edge.
REQ-009 sdata  out  1  serial data, MSB first.
REQ-010 slatch  out  1  latch pulse; the display loads its segment and LED registers on its rising edge.
REQ-011 busy  out  1  high whenever state is not IDLE.

Function
REQ-012 FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH, GAP.
REQ-013 frame_ready = 1 only in IDLE; a frame is accepted on a clk edge where frame_valid & frame_ready.
REQ-014 On accept: copy frame_data into the shift register and the hold register, load bit counter = 23, clear the divider, go to SHIFT_LO.
REQ-015 SHIFT_LO: sclk = 0 and sdata = shift-register bit 23, held for CLK_DIV cycles, then go to SHIFT_HI.
REQ-016 SHIFT_HI: sclk = 1 and sdata unchanged for CLK_DIV cycles; then shift left by 1.
REQ-017 At the end of SHIFT_HI: if bit counter = 0, go to LATCH; otherwise decrement the counter and go to SHIFT_LO.
REQ-018 sdata changes only on entry to SHIFT_LO, never while sclk = 1.
REQ-019 LATCH: sclk = 0, slatch = 1 for CLK_DIV cycles, then go to GAP.
REQ-020 GAP: sclk = 0, slatch = 0 for CLK_DIV cycles, then go to IDLE.
REQ-021 Timing for a frame accepted on edge 0: busy for cycles 1..50*CLK_DIV; frame_ready returns at cycle 50*CLK_DIV+1.
REQ-022 Exactly 24 sclk rising edges per frame; the first rising edge occurs at cycle 1+CLK_DIV.
REQ-023 In IDLE: sclk = 0, slatch = 0, sdata = 0.
REQ-024 frame_valid while busy is ignored; the requester holds the frame, and no data is dropped or overwritten mid-frame.
REQ-025 The divider and bit counter do not wrap mid-state; CLK_DIV = 1 gives a 2-cycle sclk period.

Reset
REQ-026 rst_n low immediately forces IDLE and sclk = 0, sdata = 0, slatch = 0, busy = 0, frame_ready = 0, asynchronously, including mid-frame.
REQ-027 Reset clears the shift register, hold register, bit counter, divider and refresh counter; the partial frame is abandoned and no latch pulse is issued.
REQ-028 frame_ready rises on the first clk edge after rst_n deasserts.

Configuration
REQ-029 With macro FRAME_REPEAT_EN defined: a refresh counter runs in IDLE; after IDLE_REFRESH consecutive IDLE cycles without an accept, the hold register is resent using the full sequence of REQ-014..REQ-020.
REQ-030 With FRAME_REPEAT_EN: the counter clears on every accept and on leaving IDLE; frame_valid in the expiry cycle wins and the new frame is sent; no resend occurs before the first frame after reset.
REQ-031 Without FRAME_REPEAT_EN: the refresh counter and hold register are absent and the sender stays in IDLE until frame_valid.

Verification
REQ-032 CLK_DIV=4, send 24'hA5C3F0 -> 24 sclk rises, sdata sampled 1010_0101_1100_0011_1111_0000, one slatch pulse 4 cycles wide, frame_ready high again at cycle 201.
REQ-033 Two back-to-back valid frames 24'h7F007F and 24'h000001 -> second accepted at cycle 201, both shifted intact, two latch pulses.
REQ-034 Assert rst_n low at the 10th sclk rise -> all outputs 0 within the same cycle, no slatch; after release, a new frame 24'h010101 transmits correctly.
REQ-035 CLK_DIV=1, frame 24'hFFFFFF -> sclk period 2 cycles, sdata constant 1, busy for cycles 1..50.
REQ-036 FRAME_REPEAT_EN, IDLE_REFRESH=16, one frame 24'h123456, no further valid -> identical frame resent after 16 idle cycles, repeating indefinitely; valid asserted at the expiry cycle -> new frame sent instead.
